// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int          DMEM_LAT_W     = 4;
    localparam logic [31:0] DMEM_RESP_ZERO = 32'd0;
    localparam int          LATENCY_MAX    = 15;

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
interface data_mem_resp_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_resp_array.sv
// Single-port word array: synchronous write, combinational read at the same index.
module dmem_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[addr_i];
endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency load/store responder, one access outstanding at a time.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned and out-of-range accesses.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    data_mem_resp_if.slave  bus
);
    localparam int                    AW       = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_LAT_W-1:0] CNT_LOAD = DMEM_LAT_W'(LATENCY - 1);

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    logic [DMEM_LAT_W-1:0] r_cnt;
    logic                  r_we;
    logic                  r_err;
    logic [AW-1:0]         r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err_out;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_err;
    logic                  w_mem_we;
    logic [31:0]           w_mem_rdata;
    logic                  w_addr_unused;

    // ready is forced low while reset is held so nothing is accepted then
    assign w_ready  = rst_i && (r_state != BUSY);
    assign w_accept = bus.req_i && w_ready;
    assign w_done   = (r_state == BUSY) && (r_cnt == '0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i[31:AW+2] != '0);
`else
    assign w_err = 1'b0;
`endif
    assign w_addr_unused = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == '0) w_state_nxt = RESP;
            RESP:    w_state_nxt = w_accept ? BUSY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= DMEM_RESP_ZERO;
            r_err_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_we    <= bus.we_i;
                r_err   <= w_err;
                r_idx   <= bus.addr_i[AW+1:2];
                r_wdata <= bus.wdata_i;
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // response registers carry data only for the single RESP cycle
            if (w_done) begin
                r_rdata   <= (!r_we && !r_err) ? w_mem_rdata : DMEM_RESP_ZERO;
                r_err_out <= r_err;
            end else begin
                r_rdata   <= DMEM_RESP_ZERO;
                r_err_out <= 1'b0;
            end
        end
    end

    assign w_mem_we = w_done && r_we && !r_err && rst_i;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .addr_i  (r_idx),
        .wdata_i (r_wdata),
        .rdata_o (w_mem_rdata)
    );

    assign bus.ready_o  = w_ready;
    assign bus.rvalid_o = (r_state == RESP);
    assign bus.rdata_o  = r_rdata;
    assign bus.err_o    = r_err_out;
endmodule
